led_blink_ctrl: RTL and testbench

//   Free-running LED blinker for the Tang Nano 20K board. It divides the board

---
 rtl/led_blink_ctrl.sv | 50 +++++
 tb/tb_led_blink_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// Free-running LED blinker: divides the board clock into a half-period tick
// and inverts all LED outputs together on every tick.
module led_blink_ctrl #(
  parameter int CLOCK_XTAL = 27_000_000,
  parameter int LED_NUM    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [LED_NUM-1:0] leds
);

  localparam int HALF  = CLOCK_XTAL / 2;
  localparam int CNT_W = $clog2(HALF);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  generate
    if (CLOCK_XTAL < 4) begin : g_bad_xtal
      $error("led_blink_ctrl: CLOCK_XTAL must be at least 4");
    end
  endgenerate

  logic [CNT_W-1:0]   reg_1s_cnt;
  logic               reg_cnt_1s_flg;
  logic [LED_NUM-1:0] reg_led_val;

  // The flag is raised on the same edge the counter wraps, so it is one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_1s_cnt     <= '0;
      reg_cnt_1s_flg <= 1'b0;
    end else if (reg_1s_cnt == LAST) begin
      reg_1s_cnt     <= '0;
      reg_cnt_1s_flg <= 1'b1;
    end else begin
      reg_1s_cnt     <= reg_1s_cnt + 1'b1;
      reg_cnt_1s_flg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_led_val <= '0;
    end else if (reg_cnt_1s_flg) begin
      reg_led_val <= ~reg_led_val;
    end
  end

  assign leds = reg_led_val;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl: a HALF=500 instance with 6 LEDs and
// a HALF=5 instance with 1 LED, checked against a closed-form edge-count model.
`timescale 1ns/1ps
module tb_led_blink_ctrl;

  localparam int HALF   = 500;
  localparam int SHALF  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] leds;
  logic [0:0] sleds;

  int tests_run = 0;
  int tests_failed = 0;
  int n = 0;
  int model_errs = 0;
  int led_trans = 0;
  int flg_pulses = 0;
  logic [5:0] prev_leds;
  logic       prev_flg;

  led_blink_ctrl #(.CLOCK_XTAL(1000), .LED_NUM(6)) dut (
    .clk(clk), .rst_n(rst_n), .leds(leds)
  );

  led_blink_ctrl #(.CLOCK_XTAL(10), .LED_NUM(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .leds(sleds)
  );

  always #18.5185 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [8:0] cnt;
    logic       flg;
    logic [5:0] leds;
    logic       sled;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, n, actual, expected);
    end
  endtask

  // Advance one rising edge and sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  // Model derived from the edge count since reset release.
  task automatic model_check();
    int exp_cnt, exp_flg, exp_sled;
    logic [5:0] exp_leds;
    exp_cnt  = n % HALF;
    exp_flg  = (n > 0 && (n % HALF) == 0) ? 1 : 0;
    exp_leds = (((n - 1) / HALF) % 2 == 1) ? 6'h3F : 6'h00;
    exp_sled = ((n - 1) / SHALF) % 2;
    if (int'(dut.reg_1s_cnt) > HALF - 1) model_errs++;
    if (int'(dut.reg_1s_cnt) != exp_cnt) model_errs++;
    if (int'(dut.reg_cnt_1s_flg) != exp_flg) model_errs++;
    if (leds !== 6'h00 && leds !== 6'h3F) model_errs++;
    if (leds !== exp_leds) model_errs++;
    if (int'(sleds) != exp_sled) model_errs++;
    if (prev_flg && dut.reg_cnt_1s_flg) model_errs++;
    if (dut.reg_1s_cnt == 9'd0 && !dut.reg_cnt_1s_flg) model_errs++;
    if (leds !== prev_leds) led_trans++;
    if (dut.reg_cnt_1s_flg && !prev_flg) flg_pulses++;
    prev_leds = leds;
    prev_flg  = dut.reg_cnt_1s_flg;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    n         = 0;
    prev_leds = 6'h00;
    prev_flg  = 1'b0;
    led_trans = 0;
    flg_pulses = 0;
    model_errs = 0;
  endtask

  initial begin
    vecs[0]  = '{1,    9'd1,   1'b0, 6'h00, 1'b0};
    vecs[1]  = '{5,    9'd5,   1'b0, 6'h00, 1'b0};
    vecs[2]  = '{6,    9'd6,   1'b0, 6'h00, 1'b1};
    vecs[3]  = '{10,   9'd10,  1'b0, 6'h00, 1'b1};
    vecs[4]  = '{11,   9'd11,  1'b0, 6'h00, 1'b0};
    vecs[5]  = '{499,  9'd499, 1'b0, 6'h00, 1'b1};
    vecs[6]  = '{500,  9'd0,   1'b1, 6'h00, 1'b1};
    vecs[7]  = '{501,  9'd1,   1'b0, 6'h3F, 1'b0};
    vecs[8]  = '{502,  9'd2,   1'b0, 6'h3F, 1'b0};
    vecs[9]  = '{1000, 9'd0,   1'b1, 6'h3F, 1'b1};
    vecs[10] = '{1001, 9'd1,   1'b0, 6'h00, 1'b0};
    vecs[11] = '{1500, 9'd0,   1'b1, 6'h00, 1'b1};
    vecs[12] = '{1501, 9'd1,   1'b0, 6'h3F, 1'b0};
    vecs[13] = '{2001, 9'd1,   1'b0, 6'h00, 1'b0};
    vecs[14] = '{2501, 9'd1,   1'b0, 6'h3F, 1'b0};
    vecs[15] = '{3000, 9'd0,   1'b1, 6'h3F, 1'b1};
    vecs[16] = '{3001, 9'd1,   1'b0, 6'h00, 1'b0};

    // Reset held with the clock running.
    repeat (3) @(negedge clk);
    chk("reset_leds", int'(leds), 0);
    chk("reset_cnt", int'(dut.reg_1s_cnt), 0);
    chk("reset_flg", int'(dut.reg_cnt_1s_flg), 0);
    chk("reset_small_leds", int'(sleds), 0);

    // Long run: table vectors plus per-cycle model.
    release_reset();
    begin
      int idx = 0;
      for (int c = 0; c < 3001; c++) begin
        step();
        model_check();
        if (idx < NV && vecs[idx].edge_n == n) begin
          chk("vec_cnt",  int'(dut.reg_1s_cnt),     int'(vecs[idx].cnt));
          chk("vec_flg",  int'(dut.reg_cnt_1s_flg), int'(vecs[idx].flg));
          chk("vec_leds", int'(leds),               int'(vecs[idx].leds));
          chk("vec_sled", int'(sleds),              int'(vecs[idx].sled));
          idx++;
        end
      end
      chk("table_consumed", idx, NV);
    end
    chk("per_cycle_model", model_errs, 0);
    chk("led_transitions", led_trans, 6);
    chk("flag_pulses", flg_pulses, 6);

    // Asynchronous reset between edges, mid-count.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    for (int c = 0; c < 750; c++) begin
      step();
      model_check();
    end
    chk("pre_reset_leds", int'(leds), 63);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("async_leds", int'(leds), 0);
    chk("async_cnt", int'(dut.reg_1s_cnt), 0);
    chk("async_flg", int'(dut.reg_cnt_1s_flg), 0);
    chk("async_small_leds", int'(sleds), 0);
    repeat (2) @(negedge clk);
    chk("held_leds", int'(leds), 0);

    release_reset();
    for (int c = 0; c < 501; c++) begin
      step();
      model_check();
      if (n == 500) begin
        chk("rel_flg_500", int'(dut.reg_cnt_1s_flg), 1);
        chk("rel_leds_500", int'(leds), 0);
      end
      if (n == 501) chk("rel_leds_501", int'(leds), 63);
    end
    chk("post_reset_model", model_errs, 0);
    chk("post_reset_transitions", led_trans, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
